he_frame_writer: RTL and testbench

Captures the 8-bit transformed pixel stream leaving the histogram-equalization core and writes one complete frame, in raster order, into a frame-buffer memory port. It is the output-side counterpart of the pixel streaming that feeds `HE`: it takes `transformed_pixel`-style data with a valid/ready handshake and produces addressed memory writes that honour memory backpressure. It signals completion with a `frame_done` pulse once the last pixel has been committed.

---
 rtl/he_pkg.sv | 27 ++
 rtl/he_skid_fifo.sv | 73 +++++++
 rtl/he_frame_writer.sv | 178 +++++++++++++++++
 tb/tb_he_frame_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/he_pkg.sv
// ----------------------------------------------------------------------------
// he_pkg
// Definitions shared by the histogram-equalization output path. The frame
// writer and its skid FIFO take the pixel width and the writer state encoding
// from here. The default image geometry lives here too, so every block agrees
// on the frame size.
//
// Contents:
//   PIXEL_W               width of one transformed pixel
//   DEFAULT_IMAGE_WIDTH   pixels per row used when a parent does not override it
//   DEFAULT_IMAGE_HEIGHT  rows per frame used when a parent does not override it
//   state_t               frame-writer control states
// ----------------------------------------------------------------------------
package he_pkg;

    localparam int PIXEL_W              = 8;
    localparam int DEFAULT_IMAGE_WIDTH  = 660;
    localparam int DEFAULT_IMAGE_HEIGHT = 440;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/he_skid_fifo.sv
// ----------------------------------------------------------------------------
// he_skid_fifo
// A 2-entry pixel FIFO that sits between the pixel stream and the memory write
// port. It absorbs up to two pixels while the memory stalls, so the input side
// can keep running at one pixel per cycle. A push and a pop in the same cycle
// leave the occupancy unchanged.
//
// Ports:
//   clk, reset     rising-edge clock and synchronous active-high reset.
//                  Reset empties the FIFO.
//   push_valid     producer offers push_data
//   push_ready     FIFO can take a pixel this cycle (not full)
//   push_data      pixel to store
//   pop_valid      head entry is valid (not empty)
//   pop_ready      consumer takes the head this cycle
//   pop_data       head entry
//   full, empty    occupancy flags
// ----------------------------------------------------------------------------
module he_skid_fifo
    import he_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [PIXEL_W-1:0] push_data,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [PIXEL_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    logic [PIXEL_W-1:0] slot [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push       = push_valid && push_ready;
    assign pop        = pop_ready && pop_valid;
    assign pop_data   = slot[rd_ptr];

    // The slot storage is not reset. Its content is meaningful only while
    // count says it is occupied, so reset clears only the pointers and the
    // occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/he_frame_writer.sv
// ----------------------------------------------------------------------------
// he_frame_writer
// Captures one frame of transformed pixels from the histogram-equalization
// core. It writes the frame in raster order to a frame-buffer write port and
// honours backpressure on both the pixel side and the memory side. A
// frame_done pulse marks the point where the last write has been accepted.
//
// Optional build feature:
//   HE_FRAME_WRITER_BINARIZE_EN  when defined, each written byte becomes 8'hFF
//                                for a non-zero pixel and 8'h00 for a zero
//                                pixel. The FIFO still holds the raw value,
//                                and timing is the same in both builds.
//
// Parameters:
//   IMAGE_WIDTH, IMAGE_HEIGHT   frame geometry in pixels
//   ADDR_W                      write address width (2^ADDR_W >= W*H)
//
// Ports:
//   clk, reset        rising-edge clock and synchronous active-high reset
//   start             one-cycle request to arm capture; honoured only in IDLE
//   in_pixel/in_valid/in_ready    pixel stream handshake
//   mem_addr/mem_wdata/mem_we     write request; held until mem_ready
//   mem_ready         memory accepts the write this cycle
//   busy              high from the cycle after start until frame_done ends
//   frame_done        one-cycle pulse after the last write is accepted
// ----------------------------------------------------------------------------
module he_frame_writer
    import he_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int ADDR_W       = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIXEL_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IMAGE_HEIGHT - 1);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  in_count;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               clear_counters;

    logic               fifo_push_valid;
    logic               fifo_push_ready;
    logic               fifo_pop_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PIXEL_W-1:0] fifo_head;

    logic               accept;
    logic               write_done;
    logic               last_accept;
    logic               last_write;

    // Pixels are offered to the FIFO only while a frame is running. A valid
    // pixel in any other state is dropped and never reaches memory.
    assign fifo_push_valid = in_valid && (state == RUN);
    assign accept          = fifo_push_valid && fifo_push_ready;
    assign in_ready        = (state == RUN) && !fifo_full;

    assign mem_we      = fifo_pop_valid;
    assign write_done  = fifo_pop_valid && mem_ready;
    assign mem_addr    = wr_addr;
    assign last_accept = accept && (in_count == LAST_PIXEL);
    assign last_write  = write_done && (col == LAST_COL) && (row == LAST_ROW);

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // The data bus is forced to zero whenever no write is pending. This keeps
    // mem_wdata at its reset value while idle instead of exposing a stale FIFO
    // slot.
`ifdef HE_FRAME_WRITER_BINARIZE_EN
    assign mem_wdata = {PIXEL_W{!fifo_empty && (fifo_head != '0)}};
`else
    assign mem_wdata = fifo_empty ? '0 : fifo_head;
`endif

    he_skid_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (fifo_push_valid),
        .push_ready (fifo_push_ready),
        .push_data  (in_pixel),
        .pop_valid  (fifo_pop_valid),
        .pop_ready  (mem_ready),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RUN ends on the acceptance of the final pixel. DRAIN
    // ends on the write of the final raster position, which is always the last
    // entry left in the FIFO.
    always_comb begin
        state_next     = state;
        clear_counters = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    clear_counters = 1'b1;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_write) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Input and write-side counters. The linear address and the col/row pair
    // advance together on each accepted write, so the raster address never
    // needs a multiplier.
    always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
            in_count <= '0;
            wr_addr  <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            if (accept) begin
                in_count <= in_count + ADDR_W'(1);
            end
            if (write_done) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_he_frame_writer.sv
// ----------------------------------------------------------------------------
// tb_he_frame_writer
// Self-checking bench for he_frame_writer on a 4x3 frame. A negedge monitor
// keeps a scoreboard: an expected (address, data) pair is queued for every
// accepted pixel and compared against each accepted memory write. Each
// scenario task also checks its own timing and handshake behaviour. Expected
// data comes from a small model that follows HE_FRAME_WRITER_BINARIZE_EN when
// that macro is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_he_frame_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_pixel;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_ready;
    logic          busy;
    logic          frame_done;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [7:0]    pix [N];
    wr_t           sb [$];
    wr_t           sb_entry;
    wr_t           sb_head;
    logic [AW-1:0] exp_addr;
    logic          mon_en = 1'b0;
    int            writes_seen;
    int            max_occ;
    logic          stalled = 1'b0;
    logic [AW-1:0] held_addr;
    logic [7:0]    held_data;

    // 100 MHz clock
    always #5 clk = ~clk;

    he_frame_writer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Expected memory byte for a given pixel
    function automatic logic [7:0] model_data(input logic [7:0] p);
`ifdef HE_FRAME_WRITER_BINARIZE_EN
        return (p != 8'h00) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    // Watchdog so the bench always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard monitor. At a negedge the queue size equals the DUT FIFO
    // occupancy, and the handshakes seen here are the ones the coming posedge
    // will commit.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (mem_we !== (sb.size() != 0)) begin
                miscompares++;
                $display("[TB] FAIL we_vs_occupancy: mem_we=%b expected %b", mem_we, sb.size() != 0);
            end
            vectors++;
            if (in_ready && sb.size() >= 2) begin
                miscompares++;
                $display("[TB] FAIL ready_when_full: in_ready=1 with %0d pending", sb.size());
            end
            if (stalled) begin
                vectors++;
                if (mem_we !== 1'b1 || mem_addr !== held_addr || mem_wdata !== held_data) begin
                    miscompares++;
                    $display("[TB] FAIL stall_stable: we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                             mem_we, mem_addr, mem_wdata, held_addr, held_data);
                end
            end
            if (mem_we && mem_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write: addr=%0d data=%h with empty scoreboard", mem_addr, mem_wdata);
                end else begin
                    sb_head = sb.pop_front();
                    if (mem_addr !== sb_head.addr || mem_wdata !== sb_head.data) begin
                        miscompares++;
                        $display("[TB] FAIL write: addr=%0d data=%h expected addr=%0d data=%h",
                                 mem_addr, mem_wdata, sb_head.addr, sb_head.data);
                    end
                end
                writes_seen++;
            end
            stalled   = mem_we && !mem_ready;
            held_addr = mem_addr;
            held_data = mem_wdata;
            if (in_valid && in_ready) begin
                sb_entry.addr = exp_addr;
                sb_entry.data = model_data(in_pixel);
                sb.push_back(sb_entry);
                exp_addr++;
            end
            if (sb.size() > max_occ) max_occ = sb.size();
        end else begin
            stalled = 1'b0;
        end
    end

    // Runs one full frame from start to frame_done.
    // mode 0: mem_ready always 1; mode 1: alternate cycles; mode 2: low cycles 3..7
    task automatic run_frame(input int mode, output int done_cycle, output int ready_in_stall);
        int   idx;
        logic acc;
        idx            = 0;
        done_cycle     = -1;
        ready_in_stall = 0;
        sb.delete();
        exp_addr    = '0;
        writes_seen = 0;
        max_occ     = 0;
        mon_en      = 1'b1;
        start       = 1'b1;
        mem_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_rise: busy=%b expected 1", busy);
        end
        for (int cyc = 1; cyc <= 200 && done_cycle < 0; cyc++) begin
            in_valid = (idx < N);
            in_pixel = (idx < N) ? pix[idx] : 8'h00;
            case (mode)
                1:       mem_ready = ((cyc % 2) == 0);
                2:       mem_ready = !(cyc >= 3 && cyc <= 7);
                default: mem_ready = 1'b1;
            endcase
            @(negedge clk);
            acc = in_valid && in_ready;
            if (mode == 2 && cyc >= 4 && cyc <= 8 && in_ready) ready_in_stall++;
            @(posedge clk); #1;
            if (acc) idx++;
            if (frame_done) done_cycle = cyc;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_pulse: frame_done=%b busy=%b expected 0 0", frame_done, busy);
        end
        mon_en = 1'b0;
        vectors++;
        if (writes_seen != N || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL write_count: writes=%0d pending=%0d expected %0d 0", writes_seen, sb.size(), N);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: in_ready=%b we=%b addr=%0d data=%h busy=%b done=%b expected all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Valid pixels while idle must be refused and never written
    task automatic test_idle_ignore();
        in_valid = 1'b1;
        in_pixel = 8'h55;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_ignore: in_ready=%b mem_we=%b expected 0 0", in_ready, mem_we);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dc, rs;
        for (int i = 0; i < N; i++) pix[i] = 8'(i);
        run_frame(0, dc, rs);
        vectors++;
        if (dc != N + 1) begin
            miscompares++;
            $display("[TB] FAIL frame_done_cycle: edge %0d after start expected %0d", dc, N + 1);
        end
        vectors++;
        if (max_occ != 1) begin
            miscompares++;
            $display("[TB] FAIL streaming_occupancy: max %0d expected 1", max_occ);
        end
    endtask

    task automatic test_alternate_ready();
        int dc, rs;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'hA0 + i);
        run_frame(1, dc, rs);
        vectors++;
        if (dc < 0) begin
            miscompares++;
            $display("[TB] FAIL alt_done: frame_done never seen, got %0d expected >0", dc);
        end
    endtask

    task automatic test_stall_mid_row();
        int dc, rs;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h30 + 3 * i);
        run_frame(2, dc, rs);
        vectors++;
        if (max_occ != 2) begin
            miscompares++;
            $display("[TB] FAIL stall_absorb: max held %0d expected 2", max_occ);
        end
        vectors++;
        if (rs != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_ready_low: in_ready high %0d cycles expected 0", rs);
        end
        vectors++;
        if (dc != N + 6) begin
            miscompares++;
            $display("[TB] FAIL stall_done_cycle: edge %0d expected %0d", dc, N + 6);
        end
    endtask

    task automatic test_reset_midframe();
        int   idx, dc, rs;
        logic acc;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h20 + i);
        idx       = 0;
        start     = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 50 && idx < 5; cyc++) begin
            in_valid = 1'b1;
            in_pixel = pix[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        vectors++;
        if (mem_we !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_pending: we=%b busy=%b expected 1 1", mem_we, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: in_ready=%b we=%b addr=%0d data=%h busy=%b done=%b expected all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done);
        end
        mem_ready = 1'b1;
        test_idle_ignore();
        run_frame(0, dc, rs);
        vectors++;
        if (dc != N + 1) begin
            miscompares++;
            $display("[TB] FAIL restart_done_cycle: edge %0d expected %0d", dc, N + 1);
        end
    endtask

    task automatic test_binarize();
        int dc, rs;
        pix[0] = 8'h00;
        pix[1] = 8'h01;
        pix[2] = 8'h80;
        pix[3] = 8'h00;
        for (int i = 4; i < N; i++) pix[i] = (i % 3 == 0) ? 8'h00 : 8'(8'h10 * i);
        run_frame(0, dc, rs);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        mem_ready = 1'b1;
        test_reset();
        test_idle_ignore();
        test_back_to_back();
        test_idle_ignore();
        test_alternate_ready();
        test_stall_mid_row();
        test_reset_midframe();
        test_binarize();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
